neuron_trainer: RTL and testbench
=================================

NEURON_TRAINER -- requirements
Module: neuron_trainer

Interface
REQ-001 The module SHALL take parameter NUM_IN, default 2: number of input features.
REQ-002 The module SHALL take parameter DATA_W, default 7: signed two's-complement width of each input.
REQ-003 The module SHALL take parameter WEIGHT_W, default 14: signed width of each weight and of the bias.
REQ-004 The module SHALL take parameter LR_SHL, default 0: learning rate as a left shift, eta = 2^LR_SHL.
REQ-005 The module SHALL take parameter MAX_EPOCH, default 255: epoch limit, 8-bit range.
REQ-006 The module SHALL use one clock; reset is synchronous and active-low.
REQ-007 The module SHALL have the following ports (clock and reset first):
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin training; sampled only in IDLE
- sample_count  in  32  samples per epoch; latched when start is accepted
- x_bus  in  NUM_IN*DATA_W  packed inputs; feature i at bits [i*DATA_W +: DATA_W]
- t_bus  in  2  target: 2'b01 = +1, 2'b11 = -1, other codes invalid
- sample_valid  in  1  x_bus and t_bus are valid
- sample_ready  out  1  trainer accepts a sample this cycle
- weights  out  NUM_IN*WEIGHT_W  packed weights, same layout as x_bus
- bias  out  WEIGHT_W  bias
- done  out  1  training finished; held until the next accepted start
- converged  out  1  last epoch completed with zero updates
- epoch_cnt  out  8  epochs completed

Function
REQ-008 The FSM SHALL have states IDLE, WAIT_SAMPLE, COMPUTE, UPDATE, EPOCH_END and FIN.
REQ-009 In IDLE with start=1, the module SHALL:
- latch sample_count;
- clear weights, bias, epoch_cnt, done, converged and the error flag;
- zero the sample index;
- go to WAIT_SAMPLE, or go to FIN if sample_count=0 (converged=0).
REQ-010 sample_ready SHALL equal 1 only in WAIT_SAMPLE; a sample is taken on the cycle sample_valid and sample_ready are both 1.
REQ-011 On the handshake, x and t SHALL be registered and the FSM SHALL go to COMPUTE.
REQ-012 In COMPUTE, net = bias + sum(w_i*x_i) SHALL be formed at width WEIGHT_W+DATA_W+clog2(NUM_IN+1)+1 with no overflow, and registered.
- y = +1 if net >= 0, else -1.
REQ-013 In UPDATE, if t is valid and y != t, the module SHALL apply:
- w_i += (t*x_i) <<< LR_SHL;
- bias += t <<< LR_SHL;
- each result saturates to the signed WEIGHT_W range;
- the epoch error flag is set.
REQ-014 An invalid t SHALL consume the sample with no update and no error flag.
REQ-015 After UPDATE, the sample index SHALL increment; the FSM goes to WAIT_SAMPLE, or to EPOCH_END when the index reaches sample_count.
REQ-016 In EPOCH_END, epoch_cnt SHALL increment, then:
- error flag clear: converged=1, go to FIN;
- else, epoch_cnt = MAX_EPOCH: converged=0, go to FIN;
- else: clear the index and error flag, go to WAIT_SAMPLE.
REQ-017 In FIN, done SHALL be 1 and outputs SHALL hold; FIN SHALL go to IDLE in the same cycle done is asserted.
- done stays 1 in IDLE until start is accepted.
REQ-018 Throughput SHALL be one sample per 3 cycles minimum; weights SHALL be visible the cycle after UPDATE.
REQ-019 start SHALL be ignored outside IDLE; sample_valid SHALL be ignored outside WAIT_SAMPLE.

Reset
REQ-020 With rst_n=0 at a clock edge, the module SHALL go to IDLE and clear all outputs, counters and flags to 0.
- This applies mid-training; no partial update is applied.
REQ-021 Reset SHALL take priority over start and the handshake.

Structure
REQ-022 Package neuron_pkg SHALL hold the state enum, the target encodings (T_POS=2'b01, T_NEG=2'b11) and the accumulator-width function.
REQ-023 The dot product SHALL be one sub-module, neuron_dot: combinational signed multiply-accumulate over NUM_IN lanes plus bias.

Verification
REQ-024 The bench SHALL cover:
- Defaults, count=1, x=(-16,-16), t=2'b11 -> epoch 1 updates to w=(16,16), b=-1; epoch 2 has net=-513 with no update; done=1, converged=1, epoch_cnt=2.
- WEIGHT_W=8, LR_SHL=1, x=(-64,0), t=-1 -> w1 saturates to 127, w2=0, b=-2.
- Contradictory pair, x=(5,5) with t=+1 then t=-1, MAX_EPOCH=4 -> done with converged=0, epoch_cnt=4.
- t=2'b00 sample -> consumed, weights unchanged, epoch counts toward convergence.
- rst_n=0 during COMPUTE -> next cycle weights=0, sample_ready=0, done=0; a fresh start trains normally.
- sample_valid held 0 for 10 cycles in WAIT_SAMPLE -> state, weights and sample_ready=1 all hold; start pulsed while busy has no effect.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared types and helpers for the perceptron trainer: FSM states, target
// encodings and the exact-width accumulator sizing used by the dot product.
package neuron_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SAMPLE,
    COMPUTE,
    UPDATE,
    EPOCH_END,
    FIN
  } state_e;

  localparam logic [1:0] T_POS = 2'b01;
  localparam logic [1:0] T_NEG = 2'b11;

  // Wide enough that bias + sum of NUM_IN products can never overflow.
  function automatic int unsigned acc_width(input int unsigned weight_w,
                                            input int unsigned data_w,
                                            input int unsigned num_in);
    return weight_w + data_w + $clog2(num_in + 1) + 1;
  endfunction

endpackage

// File: rtl/neuron_dot.sv
// Combinational signed multiply-accumulate: net = bias + sum(w_i * x_i).
module neuron_dot
  import neuron_pkg::*;
#(
  parameter int unsigned NUM_IN   = 2,
  parameter int unsigned DATA_W   = 7,
  parameter int unsigned WEIGHT_W = 14,
  parameter int unsigned ACC_W    = acc_width(WEIGHT_W, DATA_W, NUM_IN)
) (
  input  logic [NUM_IN*DATA_W-1:0]   x_bus,
  input  logic [NUM_IN*WEIGHT_W-1:0] w_bus,
  input  logic [WEIGHT_W-1:0]        bias,
  output logic [ACC_W-1:0]           net
);

  always_comb begin
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] xe;
    logic signed [ACC_W-1:0] we;
    acc = ACC_W'($signed(bias));
    xe  = '0;
    we  = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      xe  = ACC_W'($signed(x_bus[i*DATA_W +: DATA_W]));
      we  = ACC_W'($signed(w_bus[i*WEIGHT_W +: WEIGHT_W]));
      acc = acc + xe * we;
    end
    net = acc;
  end

endmodule

// File: rtl/neuron_trainer.sv
// Single-layer perceptron trainer: one sample per 3 cycles, saturating
// weight/bias updates, epoch loop until convergence or MAX_EPOCH.
module neuron_trainer
  import neuron_pkg::*;
#(
  parameter int unsigned NUM_IN    = 2,
  parameter int unsigned DATA_W    = 7,
  parameter int unsigned WEIGHT_W  = 14,
  parameter int unsigned LR_SHL    = 0,
  parameter int unsigned MAX_EPOCH = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [31:0]                sample_count,
  input  logic [NUM_IN*DATA_W-1:0]   x_bus,
  input  logic [1:0]                 t_bus,
  input  logic                       sample_valid,
  output logic                       sample_ready,
  output logic [NUM_IN*WEIGHT_W-1:0] weights,
  output logic [WEIGHT_W-1:0]        bias,
  output logic                       done,
  output logic                       converged,
  output logic [7:0]                 epoch_cnt
);

  localparam int unsigned ACC_W = acc_width(WEIGHT_W, DATA_W, NUM_IN);
  localparam int unsigned UPD_W = WEIGHT_W + DATA_W + LR_SHL + 2;
  localparam logic signed [UPD_W-1:0] W_MAX =
    {{(UPD_W-WEIGHT_W+1){1'b0}}, {(WEIGHT_W-1){1'b1}}};
  localparam logic signed [UPD_W-1:0] W_MIN =
    {{(UPD_W-WEIGHT_W+1){1'b1}}, {(WEIGHT_W-1){1'b0}}};
  localparam logic signed [UPD_W-1:0] ONE = UPD_W'(1);
  localparam logic [7:0] EPOCH_LIMIT = 8'(MAX_EPOCH);

  state_e                      state_q, state_d;
  logic [31:0]                 count_q, count_d;
  logic [31:0]                 idx_q, idx_d;
  logic [NUM_IN*DATA_W-1:0]    x_q, x_d;
  logic [1:0]                  t_q, t_d;
  logic [ACC_W-1:0]            net_q, net_d;
  logic [NUM_IN*WEIGHT_W-1:0]  w_q, w_d;
  logic [WEIGHT_W-1:0]         b_q, b_d;
  logic [7:0]                  epoch_q, epoch_d;
  logic                        done_q, done_d;
  logic                        conv_q, conv_d;
  logic                        err_q, err_d;

  logic [ACC_W-1:0]            net_c;
  logic [NUM_IN*WEIGHT_W-1:0]  w_upd;
  logic [WEIGHT_W-1:0]         b_upd;
  logic                        t_neg;
  logic                        t_valid;
  logic                        y_pos;

  neuron_dot #(
    .NUM_IN  (NUM_IN),
    .DATA_W  (DATA_W),
    .WEIGHT_W(WEIGHT_W),
    .ACC_W   (ACC_W)
  ) u_dot (
    .x_bus(x_q),
    .w_bus(w_q),
    .bias (b_q),
    .net  (net_c)
  );

  function automatic logic [WEIGHT_W-1:0] sat_add(input logic signed [UPD_W-1:0] a,
                                                  input logic signed [UPD_W-1:0] d);
    logic signed [UPD_W-1:0] s;
    s = a + d;
    if (s > W_MAX)      s = W_MAX;
    else if (s < W_MIN) s = W_MIN;
    return s[WEIGHT_W-1:0];
  endfunction

  assign t_neg   = (t_q == T_NEG);
  assign t_valid = (t_q == T_POS) || (t_q == T_NEG);
  assign y_pos   = ($signed(net_q) >= 0);

  // Candidate weights for a misclassified sample; t is +/-1 so t*x is a negate.
  always_comb begin
    logic signed [UPD_W-1:0] dx;
    w_upd = '0;
    dx    = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      dx = UPD_W'($signed(x_q[i*DATA_W +: DATA_W]));
      if (t_neg) dx = -dx;
      w_upd[i*WEIGHT_W +: WEIGHT_W] =
        sat_add(UPD_W'($signed(w_q[i*WEIGHT_W +: WEIGHT_W])), dx <<< LR_SHL);
    end
    b_upd = sat_add(UPD_W'($signed(b_q)), (t_neg ? -ONE : ONE) <<< LR_SHL);
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    x_d     = x_q;
    t_d     = t_q;
    net_d   = net_q;
    w_d     = w_q;
    b_d     = b_q;
    epoch_d = epoch_q;
    done_d  = done_q;
    conv_d  = conv_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          count_d = sample_count;
          w_d     = '0;
          b_d     = '0;
          epoch_d = '0;
          done_d  = 1'b0;
          conv_d  = 1'b0;
          err_d   = 1'b0;
          idx_d   = '0;
          if (sample_count == '0) begin
            done_d  = 1'b1;
            state_d = FIN;
          end else begin
            state_d = WAIT_SAMPLE;
          end
        end
      end
      WAIT_SAMPLE: begin
        if (sample_valid) begin
          x_d     = x_bus;
          t_d     = t_bus;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        net_d   = net_c;
        state_d = UPDATE;
      end
      UPDATE: begin
        if (t_valid && (y_pos != !t_neg)) begin
          w_d   = w_upd;
          b_d   = b_upd;
          err_d = 1'b1;
        end
        idx_d   = idx_q + 32'd1;
        state_d = (idx_d == count_q) ? EPOCH_END : WAIT_SAMPLE;
      end
      EPOCH_END: begin
        epoch_d = epoch_q + 8'd1;
        if (!err_q) begin
          conv_d  = 1'b1;
          done_d  = 1'b1;
          state_d = FIN;
        end else if (epoch_d == EPOCH_LIMIT) begin
          conv_d  = 1'b0;
          done_d  = 1'b1;
          state_d = FIN;
        end else begin
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = WAIT_SAMPLE;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      idx_q   <= '0;
      x_q     <= '0;
      t_q     <= '0;
      net_q   <= '0;
      w_q     <= '0;
      b_q     <= '0;
      epoch_q <= '0;
      done_q  <= 1'b0;
      conv_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      t_q     <= t_d;
      net_q   <= net_d;
      w_q     <= w_d;
      b_q     <= b_d;
      epoch_q <= epoch_d;
      done_q  <= done_d;
      conv_q  <= conv_d;
      err_q   <= err_d;
    end
  end

  assign sample_ready = (state_q == WAIT_SAMPLE);
  assign weights      = w_q;
  assign bias         = b_q;
  assign done         = done_q;
  assign converged    = conv_q;
  assign epoch_cnt    = epoch_q;

endmodule

// File: tb/tb_neuron_trainer.sv
// Directed bench for neuron_trainer: three instances (default, narrow weights
// with eta=2, MAX_EPOCH=4) sharing the sample bus, each with its own start.
module tb_neuron_trainer;

  logic        clk;
  logic        rst_n;
  logic [31:0] sample_count;
  logic [13:0] x_bus;
  logic [1:0]  t_bus;
  logic        sample_valid;
  logic        start0, start1, start2;

  logic        rdy0, rdy1, rdy2;
  logic [27:0] w0;
  logic [15:0] w1;
  logic [27:0] w2;
  logic [13:0] b0;
  logic [7:0]  b1;
  logic [13:0] b2;
  logic        done0, done1, done2;
  logic        conv0, conv1, conv2;
  logic [7:0]  ep0, ep1, ep2;

  int total;
  int bad;

  logic [13:0] vx[4];
  logic [1:0]  vt[4];
  int          nvec;

  neuron_trainer dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .sample_count(sample_count),
    .x_bus(x_bus), .t_bus(t_bus), .sample_valid(sample_valid),
    .sample_ready(rdy0), .weights(w0), .bias(b0), .done(done0),
    .converged(conv0), .epoch_cnt(ep0)
  );

  neuron_trainer #(.WEIGHT_W(8), .LR_SHL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sample_count(sample_count),
    .x_bus(x_bus), .t_bus(t_bus), .sample_valid(sample_valid),
    .sample_ready(rdy1), .weights(w1), .bias(b1), .done(done1),
    .converged(conv1), .epoch_cnt(ep1)
  );

  neuron_trainer #(.MAX_EPOCH(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .sample_count(sample_count),
    .x_bus(x_bus), .t_bus(t_bus), .sample_valid(sample_valid),
    .sample_ready(rdy2), .weights(w2), .bias(b2), .done(done2),
    .converged(conv2), .epoch_cnt(ep2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [13:0] pk(input int a, input int b);
    logic [6:0] la;
    logic [6:0] lb;
    la = a[6:0];
    lb = b[6:0];
    return {lb, la};
  endfunction

  function automatic logic sel_ready(input int s);
    case (s)
      0:       return rdy0;
      1:       return rdy1;
      default: return rdy2;
    endcase
  endfunction

  function automatic logic sel_done(input int s);
    case (s)
      0:       return done0;
      1:       return done1;
      default: return done2;
    endcase
  endfunction

  task automatic start_dut(input int s, input logic [31:0] cnt);
    @(negedge clk);
    sample_count = cnt;
    case (s)
      0:       start0 = 1'b1;
      1:       start1 = 1'b1;
      default: start2 = 1'b1;
    endcase
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  // Offers vx/vt round-robin whenever the selected DUT is ready, until done.
  task automatic feed(input int s, input int budget, output bit timed_out);
    int k;
    int cyc;
    k = 0;
    cyc = 0;
    timed_out = 1'b1;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (sel_done(s)) begin
        timed_out = 1'b0;
        break;
      end
      if (sel_ready(s)) begin
        x_bus = vx[k % nvec];
        t_bus = vt[k % nvec];
        sample_valid = 1'b1;
        k++;
      end else begin
        sample_valid = 1'b0;
      end
    end
    sample_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (rdy0 !== 1'b0) begin bad++; $display("FAIL reset_ready: got %0b want 0", rdy0); end
    total++; if (w0 !== 28'd0) begin bad++; $display("FAIL reset_w0: got %0h want 0", w0); end
    total++; if (b0 !== 14'd0) begin bad++; $display("FAIL reset_b0: got %0h want 0", b0); end
    total++; if (done0 !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b want 0", done0); end
    total++; if (conv0 !== 1'b0) begin bad++; $display("FAIL reset_conv: got %0b want 0", conv0); end
    total++; if (ep0 !== 8'd0) begin bad++; $display("FAIL reset_epoch: got %0d want 0", ep0); end
    total++; if ({w1, b1, w2, b2} !== '0) begin bad++; $display("FAIL reset_others: got %0h want 0", {w1, b1, w2, b2}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    bit to;
    vx[0] = pk(-16, -16); vt[0] = 2'b11; nvec = 1;
    start_dut(0, 1);
    feed(0, 200, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL basic_timeout: got %0b want 0", to); end
    total++; if (w0 !== {14'd16, 14'd16}) begin bad++; $display("FAIL basic_w: got %0h want %0h", w0, {14'd16, 14'd16}); end
    total++; if (b0 !== 14'h3FFF) begin bad++; $display("FAIL basic_b: got %0h want 3fff", b0); end
    total++; if (done0 !== 1'b1) begin bad++; $display("FAIL basic_done: got %0b want 1", done0); end
    total++; if (conv0 !== 1'b1) begin bad++; $display("FAIL basic_conv: got %0b want 1", conv0); end
    total++; if (ep0 !== 8'd2) begin bad++; $display("FAIL basic_epoch: got %0d want 2", ep0); end
    repeat (3) @(negedge clk);
    total++; if (done0 !== 1'b1) begin bad++; $display("FAIL basic_done_hold: got %0b want 1", done0); end
  endtask

  task automatic test_saturate;
    bit to;
    vx[0] = pk(-64, 0); vt[0] = 2'b11; nvec = 1;
    start_dut(1, 1);
    feed(1, 200, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL sat_timeout: got %0b want 0", to); end
    total++; if (w1 !== {8'd0, 8'd127}) begin bad++; $display("FAIL sat_w: got %0h want %0h", w1, {8'd0, 8'd127}); end
    total++; if (b1 !== 8'hFE) begin bad++; $display("FAIL sat_b: got %0h want fe", b1); end
    total++; if (conv1 !== 1'b1) begin bad++; $display("FAIL sat_conv: got %0b want 1", conv1); end
    total++; if (ep1 !== 8'd2) begin bad++; $display("FAIL sat_epoch: got %0d want 2", ep1); end
  endtask

  task automatic test_contradict;
    bit to;
    vx[0] = pk(5, 5); vt[0] = 2'b01;
    vx[1] = pk(5, 5); vt[1] = 2'b11;
    nvec = 2;
    start_dut(2, 2);
    feed(2, 300, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL contra_timeout: got %0b want 0", to); end
    total++; if (done2 !== 1'b1) begin bad++; $display("FAIL contra_done: got %0b want 1", done2); end
    total++; if (conv2 !== 1'b0) begin bad++; $display("FAIL contra_conv: got %0b want 0", conv2); end
    total++; if (ep2 !== 8'd4) begin bad++; $display("FAIL contra_epoch: got %0d want 4", ep2); end
    total++; if (w2 !== {14'h3FFB, 14'h3FFB}) begin bad++; $display("FAIL contra_w: got %0h want %0h", w2, {14'h3FFB, 14'h3FFB}); end
    total++; if (b2 !== 14'h3FFF) begin bad++; $display("FAIL contra_b: got %0h want 3fff", b2); end
  endtask

  task automatic test_invalid_target;
    bit to;
    vx[0] = pk(3, -4); vt[0] = 2'b00;
    vx[1] = pk(3, -4); vt[1] = 2'b10;
    nvec = 2;
    start_dut(0, 2);
    feed(0, 200, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL inval_timeout: got %0b want 0", to); end
    total++; if ({w0, b0} !== '0) begin bad++; $display("FAIL inval_wb: got %0h want 0", {w0, b0}); end
    total++; if (conv0 !== 1'b1) begin bad++; $display("FAIL inval_conv: got %0b want 1", conv0); end
    total++; if (ep0 !== 8'd1) begin bad++; $display("FAIL inval_epoch: got %0d want 1", ep0); end
    // zero-length epoch finishes immediately without convergence
    start_dut(0, 0);
    total++; if (done0 !== 1'b1) begin bad++; $display("FAIL zero_done: got %0b want 1", done0); end
    total++; if (conv0 !== 1'b0) begin bad++; $display("FAIL zero_conv: got %0b want 0", conv0); end
    total++; if (ep0 !== 8'd0) begin bad++; $display("FAIL zero_epoch: got %0d want 0", ep0); end
  endtask

  task automatic test_reset_mid;
    bit to;
    int hs;
    vx[0] = pk(-16, -16); vt[0] = 2'b11; nvec = 1;
    start_dut(0, 2);
    hs = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge clk);
      if (hs == 2) break;
      if (rdy0) begin
        x_bus = vx[0]; t_bus = vt[0]; sample_valid = 1'b1; hs++;
      end else begin
        sample_valid = 1'b0;
      end
    end
    sample_valid = 1'b0;
    total++; if (hs !== 2) begin bad++; $display("FAIL mid_handshakes: got %0d want 2", hs); end
    total++; if (w0 !== {14'd16, 14'd16}) begin bad++; $display("FAIL mid_w_before: got %0h want %0h", w0, {14'd16, 14'd16}); end
    rst_n = 1'b0;
    @(negedge clk);
    total++; if ({w0, b0} !== '0) begin bad++; $display("FAIL mid_wb_cleared: got %0h want 0", {w0, b0}); end
    total++; if (rdy0 !== 1'b0) begin bad++; $display("FAIL mid_ready: got %0b want 0", rdy0); end
    total++; if (done0 !== 1'b0) begin bad++; $display("FAIL mid_done: got %0b want 0", done0); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if ({w0, b0} !== '0) begin bad++; $display("FAIL mid_no_partial: got %0h want 0", {w0, b0}); end
    start_dut(0, 1);
    feed(0, 200, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL mid_retrain_timeout: got %0b want 0", to); end
    total++; if ({w0, b0} !== {14'd16, 14'd16, 14'h3FFF}) begin bad++; $display("FAIL mid_retrain_wb: got %0h want %0h", {w0, b0}, {14'd16, 14'd16, 14'h3FFF}); end
    total++; if (ep0 !== 8'd2) begin bad++; $display("FAIL mid_retrain_epoch: got %0d want 2", ep0); end
  endtask

  task automatic test_stall_busy_start;
    bit to;
    bit seen;
    vx[0] = pk(-16, -16); vt[0] = 2'b11; nvec = 1;
    start_dut(0, 1);
    seen = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (rdy0) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL stall_ready_seen: got %0b want 1", seen); end
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cyc == 4) begin start0 = 1'b1; sample_count = 32'd0; end
      @(negedge clk);
      start0 = 1'b0;
      total++;
      if ({rdy0, done0, w0, b0} !== {1'b1, 1'b0, 42'd0}) begin
        bad++;
        $display("FAIL stall_hold c%0d: got rdy=%0b done=%0b wb=%0h want rdy=1 done=0 wb=0", cyc, rdy0, done0, {w0, b0});
      end
    end
    sample_count = 32'd1;
    feed(0, 200, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL stall_timeout: got %0b want 0", to); end
    total++; if ({w0, b0} !== {14'd16, 14'd16, 14'h3FFF}) begin bad++; $display("FAIL stall_wb: got %0h want %0h", {w0, b0}, {14'd16, 14'd16, 14'h3FFF}); end
    total++; if (conv0 !== 1'b1) begin bad++; $display("FAIL stall_conv: got %0b want 1", conv0); end
    total++; if (ep0 !== 8'd2) begin bad++; $display("FAIL stall_epoch: got %0d want 2", ep0); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    sample_count = '0;
    x_bus = '0;
    t_bus = '0;
    sample_valid = 1'b0;
    nvec = 1;
    test_reset;
    test_basic;
    test_saturate;
    test_contradict;
    test_invalid_target;
    test_reset_mid;
    test_stall_busy_start;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
